// File: rtl/rtc_bus_sequencer_pkg.sv
// rtl/rtc_bus_sequencer_pkg.sv - shared states, timing defaults, phase encoding and width helper
package rtc_bus_pkg;

    typedef enum logic [3:0] {
        IDLE,
        A_SETUP,
        A_PULSE,
        A_HOLD,
        A_GAP,
        D_SETUP,
        D_PULSE,
        D_HOLD,
        D_GAP,
        FIN
    } state_e;

    localparam int DEF_T_SETUP = 2;
    localparam int DEF_T_PULSE = 4;
    localparam int DEF_T_HOLD  = 2;
    localparam int DEF_T_GAP   = 2;

    localparam logic ADDR_PHASE = 1'b0;
    localparam logic DATA_PHASE = 1'b1;

    // Bits needed to hold 0..value-1; never less than one so degenerate
    // parameter choices still yield legal vectors.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/rtc_bus_sequencer_if.sv
// rtl/rtc_bus_sequencer_if.sv - command, register-stream and RTC bus signals (abort pair with RTC_ABORT_EN)
interface rtc_bus_sequencer_if
    import rtc_bus_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int MAX_REGS = 16
);
    localparam int CNT_W = clog2(MAX_REGS + 1);
    localparam int IDX_W = clog2(MAX_REGS);

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [DATA_W-1:0] req_addr;
    logic [CNT_W-1:0]  req_count;
    logic              busy;
    logic              done;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic [DATA_W-1:0] bus_out;
    logic              bus_oe;
    logic [DATA_W-1:0] bus_in;
    logic              CS_n;
    logic              RD_n;
    logic              WR_n;
    logic              A_D;

`ifdef RTC_ABORT_EN
    logic              abort;
    logic              aborted;

    modport slave (
        input  req_valid, req_write, req_addr, req_count, wdata, bus_in, abort,
        output req_ready, busy, done, idx, rdata, rdata_valid,
        output bus_out, bus_oe, CS_n, RD_n, WR_n, A_D, aborted
    );

    modport master (
        output req_valid, req_write, req_addr, req_count, wdata, bus_in, abort,
        input  req_ready, busy, done, idx, rdata, rdata_valid,
        input  bus_out, bus_oe, CS_n, RD_n, WR_n, A_D, aborted
    );
`else
    modport slave (
        input  req_valid, req_write, req_addr, req_count, wdata, bus_in,
        output req_ready, busy, done, idx, rdata, rdata_valid,
        output bus_out, bus_oe, CS_n, RD_n, WR_n, A_D
    );

    modport master (
        output req_valid, req_write, req_addr, req_count, wdata, bus_in,
        input  req_ready, busy, done, idx, rdata, rdata_valid,
        input  bus_out, bus_oe, CS_n, RD_n, WR_n, A_D
    );
`endif

endinterface

// File: rtl/rtc_phase_timer.sv
// rtl/rtc_phase_timer.sv - per-state down-counter flagging the final clock of a timed state
module rtc_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         last_o
);
    logic [W-1:0] cnt_q;

    // Reload with the state's length minus one on every state change, then count to zero and park.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign last_o = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// rtl/rtc_bus_sequencer.sv - burst read/write sequencer for the RTC multiplexed bus (optional RTC_ABORT_EN)
module rtc_bus_sequencer
    import rtc_bus_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int MAX_REGS = 16,
    parameter int T_SETUP  = DEF_T_SETUP,
    parameter int T_PULSE  = DEF_T_PULSE,
    parameter int T_HOLD   = DEF_T_HOLD,
    parameter int T_GAP    = DEF_T_GAP
) (
    input logic                reloj,
    input logic                resetM,
    rtc_bus_sequencer_if.slave bus
);
    localparam int CNT_W  = clog2(MAX_REGS + 1);
    localparam int IDX_W  = clog2(MAX_REGS);
    localparam int T_MAX1 = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int T_MAX2 = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
    localparam int T_MAX  = (T_MAX1 > T_MAX2) ? T_MAX1 : T_MAX2;
    localparam int TMR_W  = clog2(T_MAX);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cs_n_q, cs_n_d;
    logic              rd_n_q, rd_n_d;
    logic              wr_n_q, wr_n_d;
    logic              a_d_q, a_d_d;
    logic              oe_q, oe_d;
    logic [DATA_W-1:0] bus_out_q, bus_out_d;

    logic              tmr_last;
    logic              last_reg;
    logic              stop_now;

`ifdef RTC_ABORT_EN
    logic              abort_pend_q, abort_pend_d;
    logic              aborted_q, aborted_d;
    assign stop_now = abort_pend_q | bus.abort;
`else
    assign stop_now = 1'b0;
`endif

    assign last_reg = (CNT_W'(idx_q) == (count_q - 1'b1));

    function automatic logic [TMR_W-1:0] phase_len(input state_e s);
        case (s)
            A_SETUP, D_SETUP: return TMR_W'(T_SETUP - 1);
            A_PULSE, D_PULSE: return TMR_W'(T_PULSE - 1);
            A_HOLD,  D_HOLD:  return TMR_W'(T_HOLD - 1);
            A_GAP,   D_GAP:   return TMR_W'(T_GAP - 1);
            default:          return '0;
        endcase
    endfunction

    rtc_phase_timer #(.W(TMR_W)) u_timer (
        .clk_i      (reloj),
        .rst_i      (resetM),
        .load_i     (state_d != state_q),
        .load_val_i (phase_len(state_d)),
        .last_o     (tmr_last)
    );

    // Next state, burst context and the registered bus pins derived from the state being entered.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        count_d  = count_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    addr_d  = bus.req_addr;
                    count_d = (bus.req_count > CNT_W'(MAX_REGS)) ? CNT_W'(MAX_REGS) : bus.req_count;
                    idx_d   = '0;
                    state_d = (bus.req_count == '0) ? FIN : A_SETUP;
                end
            end
            A_SETUP: if (tmr_last) state_d = A_PULSE;
            A_PULSE: if (tmr_last) state_d = A_HOLD;
            A_HOLD:  if (tmr_last) state_d = A_GAP;
            A_GAP: begin
                if (tmr_last) begin
                    if (stop_now) begin
                        state_d = FIN;
                    end else begin
                        state_d = D_SETUP;
                        wdata_d = bus.wdata;
                    end
                end
            end
            D_SETUP: if (tmr_last) state_d = D_PULSE;
            D_PULSE: begin
                if (tmr_last) begin
                    state_d = D_HOLD;
                    if (!write_q) begin
                        rdata_d  = bus.bus_in;
                        rvalid_d = 1'b1;
                    end
                end
            end
            D_HOLD:  if (tmr_last) state_d = D_GAP;
            D_GAP: begin
                if (tmr_last) begin
                    if (stop_now || last_reg) begin
                        state_d = FIN;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = A_SETUP;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d == FIN || state_d == IDLE) begin
            idx_d = '0;
        end
        if (state_d == IDLE) begin
            rdata_d = '0;
        end

        busy_d    = (state_d != IDLE);
        done_d    = (state_d == FIN);
        cs_n_d    = 1'b1;
        rd_n_d    = 1'b1;
        wr_n_d    = 1'b1;
        a_d_d     = DATA_PHASE;
        oe_d      = 1'b0;
        bus_out_d = '0;

        case (state_d)
            A_SETUP, A_PULSE, A_HOLD: begin
                cs_n_d    = 1'b0;
                a_d_d     = ADDR_PHASE;
                oe_d      = 1'b1;
                bus_out_d = addr_d + DATA_W'(idx_d);
                wr_n_d    = (state_d != A_PULSE);
            end
            A_GAP: a_d_d = ADDR_PHASE;
            D_SETUP, D_PULSE, D_HOLD: begin
                cs_n_d    = 1'b0;
                oe_d      = write_d;
                bus_out_d = write_d ? wdata_d : '0;
                wr_n_d    = !(write_d && state_d == D_PULSE);
                rd_n_d    = !(!write_d && state_d == D_PULSE);
            end
            default: ;
        endcase

`ifdef RTC_ABORT_EN
        abort_pend_d = (state_q == IDLE) ? 1'b0 : (abort_pend_q | bus.abort);
        aborted_d    = (state_d == FIN) && (state_q != IDLE) && stop_now;
`endif
    end

    // Sequencer state and every bus-facing output register; reset lands in the idle pin state at once.
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            count_q      <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cs_n_q       <= 1'b1;
            rd_n_q       <= 1'b1;
            wr_n_q       <= 1'b1;
            a_d_q        <= DATA_PHASE;
            oe_q         <= 1'b0;
            bus_out_q    <= '0;
`ifdef RTC_ABORT_EN
            abort_pend_q <= 1'b0;
            aborted_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            count_q      <= count_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cs_n_q       <= cs_n_d;
            rd_n_q       <= rd_n_d;
            wr_n_q       <= wr_n_d;
            a_d_q        <= a_d_d;
            oe_q         <= oe_d;
            bus_out_q    <= bus_out_d;
`ifdef RTC_ABORT_EN
            abort_pend_q <= abort_pend_d;
            aborted_q    <= aborted_d;
`endif
        end
    end

    assign bus.req_ready   = (state_q == IDLE);
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.idx         = idx_q;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rvalid_q;
    assign bus.bus_out     = bus_out_q;
    assign bus.bus_oe      = oe_q;
    assign bus.CS_n        = cs_n_q;
    assign bus.RD_n        = rd_n_q;
    assign bus.WR_n        = wr_n_q;
    assign bus.A_D         = a_d_q;
`ifdef RTC_ABORT_EN
    assign bus.aborted     = aborted_q;
`endif

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb/tb_rtc_bus_sequencer.sv - self-checking bench for rtc_bus_sequencer (covers RTC_ABORT_EN when defined)
module tb_rtc_bus_sequencer;
    localparam int DW  = 8;
    localparam int MR  = 16;
    localparam int TS  = 2;
    localparam int TP  = 4;
    localparam int TH  = 2;
    localparam int TG  = 2;
    localparam int TT  = TS + TP + TH + TG;
    localparam int PER = 2 * TT;

    logic reloj = 1'b0;
    logic resetM;
    always #5 reloj = ~reloj;

    rtc_bus_sequencer_if #(.DATA_W(DW), .MAX_REGS(MR)) bif ();

    rtc_bus_sequencer #(
        .DATA_W(DW), .MAX_REGS(MR), .T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_GAP(TG)
    ) dut (
        .reloj  (reloj),
        .resetM (resetM),
        .bus    (bif)
    );

    logic [7:0] wmem [16];
    logic [7:0] rmem [16];
    assign bif.wdata  = wmem[bif.idx];
    assign bif.bus_in = rmem[bif.idx];

    typedef struct packed {
        logic       req_ready, busy, done, rdv, cs_n, rd_n, wr_n, a_d, oe, aborted;
        logic [3:0] idx;
        logic [7:0] bus_out, rdata;
    } obs_t;

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        int         cnt;
        int         exp_lat;
        int         exp_xfers;
        logic [7:0] exp_last;
    } vec_t;

    int total = 0;
    int bad   = 0;

    function automatic obs_t sample();
        obs_t s;
        s.req_ready = bif.req_ready;
        s.busy      = bif.busy;
        s.done      = bif.done;
        s.rdv       = bif.rdata_valid;
        s.cs_n      = bif.CS_n;
        s.rd_n      = bif.RD_n;
        s.wr_n      = bif.WR_n;
        s.a_d       = bif.A_D;
        s.oe        = bif.bus_oe;
`ifdef RTC_ABORT_EN
        s.aborted   = bif.aborted;
`else
        s.aborted   = 1'b0;
`endif
        s.idx       = bif.idx;
        s.bus_out   = bif.bus_out;
        s.rdata     = bif.rdata;
        return s;
    endfunction

    function automatic obs_t idle_obs();
        obs_t e;
        e = '0;
        e.req_ready = 1'b1;
        e.cs_n = 1'b1;
        e.rd_n = 1'b1;
        e.wr_n = 1'b1;
        e.a_d  = 1'b1;
        return e;
    endfunction

    // Expected pins k clocks after accept, from the per-register timeline arithmetic.
    function automatic obs_t model(input int k, input bit wr, input logic [7:0] addr,
                                   input int fin_k, input bit ab, input logic [7:0] cur_rd);
        obs_t e;
        int   r, o, q;
        bit   gap, pulse;
        e = idle_obs();
        e.req_ready = 1'b0;
        e.busy      = 1'b1;
        e.rdata     = cur_rd;
        if (k == fin_k) begin
            e.done    = 1'b1;
            e.aborted = ab;
            return e;
        end
        r     = (k - 1) / PER;
        o     = (k - 1) % PER;
        q     = o % TT;
        gap   = (q >= TS + TP + TH);
        pulse = (q >= TS) && (q < TS + TP);
        e.idx  = r[3:0];
        e.cs_n = gap;
        if (o < TT) begin
            e.a_d     = 1'b0;
            e.oe      = !gap;
            e.bus_out = gap ? 8'h00 : 8'(addr + r);
            e.wr_n    = !pulse;
        end else if (wr) begin
            e.oe      = !gap;
            e.bus_out = gap ? 8'h00 : wmem[r];
            e.wr_n    = !pulse;
        end else begin
            e.rd_n = !pulse;
            if (q == TS + TP) begin
                e.rdv   = 1'b1;
                e.rdata = rmem[r];
            end
        end
        return e;
    endfunction

    task automatic check(input string nm, input obs_t got, input obs_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", nm, got, exp);
        end
    endtask

    task automatic run_cmd(input string nm, input bit wr, input logic [7:0] addr, input int cnt,
                           input bit hold_valid, input int abort_k,
                           output int lat, output int xfers, output logic [7:0] last_addr);
        int         n, fin_k, ph, guard;
        bit         ab, prev_cs;
        logic [7:0] cur_rd;
        obs_t       g, e;
        n     = (cnt > MR) ? MR : cnt;
        fin_k = n * PER + 1;
        ab    = 1'b0;
        if (abort_k > 0 && abort_k < fin_k) begin
            ab = 1'b1;
            ph = (abort_k - 1) / TT;
            if ((ph + 1) * TT + 1 < fin_k) fin_k = (ph + 1) * TT + 1;
        end
        guard = 0;
        while (bif.req_ready !== 1'b1 && guard < 100) begin
            @(posedge reloj); #1;
            guard++;
        end
        check_int({nm, " ready"}, int'(bif.req_ready === 1'b1), 1);
        bif.req_valid = 1'b1;
        bif.req_write = wr;
        bif.req_addr  = addr;
        bif.req_count = 5'(cnt);
        @(posedge reloj); #1;
        bif.req_valid = hold_valid;
        bif.req_addr  = ~addr;
        bif.req_count = 5'd1;
        bif.req_write = ~wr;
        lat = -1; xfers = 0; last_addr = 8'h00; prev_cs = 1'b1; cur_rd = 8'h00;
        for (int k = 1; k <= fin_k; k++) begin
            g = sample();
            e = model(k, wr, addr, fin_k, ab, cur_rd);
            cur_rd = e.rdata;
            check($sformatf("%s k=%0d", nm, k), g, e);
            if (g.done && lat < 0) lat = k;
            if (prev_cs && !g.cs_n && !g.a_d) begin
                xfers++;
                last_addr = g.bus_out;
            end
            prev_cs = g.cs_n;
`ifdef RTC_ABORT_EN
            bif.abort = (k == abort_k);
`endif
            if (k == fin_k) bif.req_valid = 1'b0;
            @(posedge reloj); #1;
        end
`ifdef RTC_ABORT_EN
        bif.abort = 1'b0;
`endif
        check({nm, " idle after"}, sample(), idle_obs());
    endtask

    vec_t       vecs [5];
    int         lat, xf;
    logic [7:0] la;

    initial begin
        resetM        = 1'b0;
        bif.req_valid = 1'b0;
        bif.req_write = 1'b0;
        bif.req_addr  = 8'h00;
        bif.req_count = 5'd0;
`ifdef RTC_ABORT_EN
        bif.abort     = 1'b0;
`endif
        for (int i = 0; i < 16; i++) begin
            wmem[i] = 8'(i * 17 + 3);
            rmem[i] = 8'(i * 29 + 7);
        end
        wmem[0] = 8'h45;
        rmem[0] = 8'h10;
        rmem[1] = 8'h20;
        rmem[2] = 8'h30;

        vecs[0] = '{1'b1, 8'h21, 1,  21,  1,  8'h21};
        vecs[1] = '{1'b0, 8'h22, 3,  61,  3,  8'h24};
        vecs[2] = '{1'b1, 8'hFE, 20, 321, 16, 8'h0D};
        vecs[3] = '{1'b0, 8'h10, 0,  1,   0,  8'h00};
        vecs[4] = '{1'b0, 8'hFF, 2,  41,  2,  8'h00};

        #1 resetM = 1'b1;
        #2;
        check("reset state", sample(), idle_obs());
        @(posedge reloj); @(posedge reloj); #1;
        resetM = 1'b0;

        for (int v = 0; v < 5; v++) begin
            run_cmd($sformatf("vec%0d", v), vecs[v].wr, vecs[v].addr, vecs[v].cnt, 1'b0, 0, lat, xf, la);
            check_int($sformatf("vec%0d latency", v), lat, vecs[v].exp_lat);
            check_int($sformatf("vec%0d transfers", v), xf, vecs[v].exp_xfers);
            check_int($sformatf("vec%0d last addr", v), int'(la), int'(vecs[v].exp_last));
        end

        run_cmd("busy ignore", 1'b1, 8'h60, 2, 1'b1, 0, lat, xf, la);
        check_int("busy ignore latency", lat, 2 * PER + 1);
        check_int("busy ignore transfers", xf, 2);

        bif.req_valid = 1'b1;
        bif.req_write = 1'b1;
        bif.req_addr  = 8'h30;
        bif.req_count = 5'd3;
        @(posedge reloj); #1;
        bif.req_valid = 1'b0;
        for (int k = 1; k < PER + TS + 1; k++) begin
            @(posedge reloj); #1;
        end
        check_int("pre-reset WR_n", int'(bif.WR_n), 0);
        check_int("pre-reset idx", int'(bif.idx), 1);
        #2 resetM = 1'b1;
        #1;
        check("reset mid-burst", sample(), idle_obs());
        @(posedge reloj); #1;
        resetM = 1'b0;
        run_cmd("after reset", 1'b0, 8'h70, 2, 1'b0, 0, lat, xf, la);
        check_int("after reset latency", lat, 2 * PER + 1);

`ifdef RTC_ABORT_EN
        rmem[0] = 8'h11;
        rmem[1] = 8'h22;
        run_cmd("abort", 1'b0, 8'h40, 4, 1'b0, PER + TT + TS + 1, lat, xf, la);
        check_int("abort latency", lat, 4 * TT + 1);
        check_int("abort transfers", xf, 2);
        bif.abort = 1'b1;
        @(posedge reloj); #1;
        run_cmd("idle abort", 1'b1, 8'h50, 1, 1'b0, 0, lat, xf, la);
        check_int("idle abort latency", lat, PER + 1);
`endif

        for (int t = 0; t < 8; t++) begin
            int         c, n;
            bit         w;
            logic [7:0] a;
            for (int i = 0; i < 16; i++) begin
                wmem[i] = 8'($urandom);
                rmem[i] = 8'($urandom);
            end
            w = 1'($urandom_range(0, 1));
            a = 8'($urandom);
            c = int'($urandom_range(0, 20));
            n = (c > MR) ? MR : c;
            run_cmd($sformatf("rand%0d", t), w, a, c, 1'b0, 0, lat, xf, la);
            check_int($sformatf("rand%0d latency", t), lat, n * PER + 1);
            check_int($sformatf("rand%0d transfers", t), xf, n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rtc_bus_sequencer.md
Name: rtc_bus_sequencer

Overview:
Parametrised successor to the RTC control path's fixed signal generator.
- Executes burst read or write transactions of 1..MAX_REGS consecutive registers over the RTC's multiplexed address/data bus, with programmable per-phase timing.
- Sits between the general control FSM (command side) and the top-level DIR_DATO tristate (bus side).
- Feeds the register mux/demux through an index/data streaming interface.

Parameters:
DATA_W, 8, bus and data width (address uses the same bus, so address width equals DATA_W)
MAX_REGS, 16, maximum registers per burst
T_SETUP, 2, clocks with CS_n low and strobe high before the strobe (>=1)
T_PULSE, 4, clocks the strobe (RD_n/WR_n) is low (>=1)
T_HOLD, 2, clocks with CS_n low after the strobe rises (>=1)
T_GAP, 2, clocks with CS_n high between phases (>=1)

Ports:
reloj  in  1  system clock, rising edge
resetM  in  1  asynchronous, active-high reset
req_valid  in  1  command request
req_ready  out  1  high only in IDLE; a command is accepted on req_valid&&req_ready
req_write  in  1  1 = write burst, 0 = read burst
req_addr  in  DATA_W  first RTC register address
req_count  in  clog2(MAX_REGS+1)  number of registers
busy  out  1  command in progress
done  out  1  one-clock pulse at command end
idx  out  clog2(MAX_REGS)  register index of the current transfer (selects the write mux / read demux)
wdata  in  DATA_W  write data for idx, combinationally valid
rdata  out  DATA_W  captured read data
rdata_valid  out  1  one-clock pulse; rdata belongs to idx
bus_out  out  DATA_W  driven value for DIR_DATO
bus_oe  out  1  1 = drive DIR_DATO
bus_in  in  DATA_W  sampled DIR_DATO
CS_n, RD_n, WR_n  out  1 each  active-low chip select and strobes
A_D  out  1  0 = address phase, 1 = data phase

Behaviour:
- Reset and idle values:
  - CS_n = RD_n = WR_n = 1, A_D = 1, bus_oe = 0, bus_out = 0.
  - busy = done = rdata_valid = 0, idx = 0, rdata = 0, req_ready = 1.
  - Reset asserted mid-burst forces this state immediately; no partial cycle completes.
- On accept:
  - Latch req_write and req_addr.
  - Latch count = min(req_count, MAX_REGS).
  - busy goes high the next cycle.
  - req_count == 0: skip bus activity; pulse done in the next cycle.
- FSM states: IDLE, A_SETUP, A_PULSE, A_HOLD, A_GAP, D_SETUP, D_PULSE, D_HOLD, D_GAP, FIN.
  - Each timed state lasts exactly its T_* clocks, then advances in the order listed.
  - D_GAP exit: if idx == count-1, go to FIN; otherwise increment idx and go to A_SETUP.
  - FIN: done = 1 for one clock, then IDLE.
- Address phase:
  - A_D = 0, bus_oe = 1, bus_out = (addr_base + idx) mod 2^DATA_W; wraps 0xFF -> 0x00 at DATA_W = 8.
  - CS_n low in SETUP, PULSE and HOLD.
  - WR_n low in A_PULSE.
- Data phase:
  - A_D = 1; CS_n low in SETUP, PULSE and HOLD.
  - Write burst: wdata is registered on entry to D_SETUP and held through D_HOLD. bus_oe = 1. WR_n low in D_PULSE.
  - Read burst: bus_oe = 0 for the whole data phase. RD_n low in D_PULSE. bus_in is captured into rdata on the last D_PULSE clock. rdata_valid pulses on the first D_HOLD clock.
- Gap states: CS_n high, bus_oe = 0 in both A_GAP and D_GAP.
- Glitch-free strobes: RD_n, WR_n, CS_n, A_D and bus_oe are all registered outputs, and RD_n and WR_n are never low at the same time.
- Timing:
  - Per-register time: 2*(T_SETUP+T_PULSE+T_HOLD+T_GAP) clocks (20 at defaults).
  - Accept-to-done: count*that + 1 clocks.
- req_valid while busy is ignored; req_ready stays low.

Optional Feature:
RTC_ABORT_EN
- With the macro: adds input abort (1 bit) and output aborted (1 bit).
  - abort seen in any non-IDLE state sets a pending flag.
  - The current phase completes through its HOLD and GAP states; no further phases start.
  - FIN then pulses done together with aborted.
  - Abort in IDLE is ignored.
- Without the macro: neither port exists; bursts always run to completion.

Decomposition:
- Package rtc_bus_pkg holds:
  - state enum
  - default T_* constants
  - A_D encoding constants (ADDR_PHASE = 0, DATA_PHASE = 1)
  - clog2 helper
- Sub-module rtc_phase_timer:
  - Down-counter loaded with T_x-1 on each state entry.
  - Emits a last-cycle flag.
  - Width is clog2 of the largest T_*.

Test Plan:
- Reset mid-burst: assert resetM during A_PULSE of register 1 -> all outputs return to idle values asynchronously; a new request after release starts at idx 0.
- Single write: addr = 0x21, count = 1, wdata = 0x45 ->
  - A_SETUP..A_HOLD shows bus_out = 0x21, A_D = 0, WR_n low for 4 clocks.
  - Data phase shows bus_out = 0x45, A_D = 1, WR_n low for 4 clocks.
  - done 21 clocks after accept.
- Read burst: addr = 0x22, count = 3, bus_in model returns 0x10, 0x20, 0x30 -> three rdata_valid pulses with idx 0, 1, 2 and rdata 0x10, 0x20, 0x30; bus_oe = 0 in every data phase; done at clock 61.
- Wrap and clamp: addr = 0xFE, count = 20 with MAX_REGS = 16 -> exactly 16 transfers; addresses 0xFE, 0xFF, 0x00 .. 0x0D.
- Zero count and back-pressure:
  - count = 0 -> done the next clock with no CS_n activity.
  - A second req_valid during a burst -> ignored; req_ready = 0.
- Abort (RTC_ABORT_EN): abort during D_PULSE of idx 1 of a 4-register read -> idx 1 completes with rdata_valid, then FIN with done = aborted = 1; no address phase for idx 2.
